gray_count_sequencer: RTL

//  Run controller for the Gray-code counter datapath: a binary counter plus a registered binary-to-Gray converter.
//  An FSM starts, pauses, stops and terminates count runs.

---
 rtl/gray_count_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/gray_count_sequencer.sv
// Run controller for a Gray-code counter: binary count plus registered Gray conversion,
// with start/stop/pause sequencing and a valid/ready hand-off to a downstream consumer.
module gray_count_sequencer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic         wrap_mode,
  input  logic [W-1:0] limit,
  output logic         gray_valid,
  input  logic         gray_ready,
  output logic [W-1:0] gray_out,
  output logic [W-1:0] bin_out,
  output logic         busy,
  output logic         done,
  output logic         wrapped
);

  typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] gray_q, gray_d;
  logic [W-1:0] limit_q, limit_d;
  logic         mode_q, mode_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;
  logic         wrapped_q, wrapped_d;
  logic         xfer;

  assign xfer = valid_q && gray_ready;

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    limit_d   = limit_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    wrapped_d = 1'b0;

    if (stop) begin
      state_d = StIdle;
      bin_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          bin_d = '0;
          if (start) begin
            limit_d = limit;
            mode_d  = wrap_mode;
            state_d = StRun;
          end
        end
        StRun: begin
          if (xfer) begin
            if (bin_q == limit_q) begin
              if (mode_q) begin
                bin_d     = '0;
                wrapped_d = 1'b1;
              end else begin
                state_d = StDone;
                done_d  = 1'b1;
              end
            end else begin
              bin_d = bin_q + 1'b1;
            end
          end
          // A transfer in the same cycle as pause still lands; only then do we freeze.
          if (pause && state_d == StRun) begin
            state_d = StHold;
          end
        end
        StHold: begin
          if (!pause) begin
            state_d = StRun;
          end
        end
        StDone: begin
          if (start) begin
            limit_d = limit;
            mode_d  = wrap_mode;
            bin_d   = '0;
            state_d = StRun;
          end
        end
        default: begin
          state_d = StIdle;
          bin_d   = '0;
        end
      endcase
    end

    gray_d  = bin_d ^ (bin_d >> 1);
    valid_d = (state_d == StRun);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      gray_q    <= '0;
      limit_q   <= '0;
      mode_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      gray_q    <= gray_d;
      limit_q   <= limit_d;
      mode_q    <= mode_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign gray_valid = valid_q;
  assign gray_out   = gray_q;
  assign bin_out    = bin_q;
  assign busy       = (state_q == StRun) || (state_q == StHold);
  assign done       = done_q;
  assign wrapped    = wrapped_q;

endmodule
